// File: rtl/sorted_list.sv
// Sorted storage of up to LENGTH unsigned entries. The entries are ordered ascending or
// descending by parameter. Requests are single-issue over a valid/ready port.
module sorted_list #(
    parameter int  DATA_WIDTH = 32,
    parameter int  LENGTH     = 8,
    parameter int  ORDER      = 0,
    parameter int  ALLOW_DUP  = 1,
    localparam int IDX_W      = $clog2(LENGTH),
    localparam int CNT_W      = $clog2(LENGTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [2:0]            op_sel,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [IDX_W-1:0]      index_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [IDX_W-1:0]      index_out,
    output logic                  res_valid,
    output logic                  op_error,
    output logic [CNT_W-1:0]      len,
    output logic                  full,
    output logic                  empty
);

    localparam logic [2:0] OP_READ    = 3'b000;
    localparam logic [2:0] OP_INSERT  = 3'b001;
    localparam logic [2:0] OP_FIND    = 3'b010;
    localparam logic [2:0] OP_DEL_IDX = 3'b011;
    localparam logic [2:0] OP_DEL_VAL = 3'b100;
    localparam logic [2:0] OP_MIN     = 3'b101;
    localparam logic [2:0] OP_MAX     = 3'b110;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOCATE = 3'd1;
    localparam logic [2:0] S_SEARCH = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(LENGTH);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [DATA_WIDTH-1:0] mem_q [LENGTH];
    logic [DATA_WIDTH-1:0] mem_d [LENGTH];
    logic [CNT_W-1:0]      len_q, len_d;
    logic [CNT_W-1:0]      lo_q, lo_d;
    logic [CNT_W-1:0]      hi_q, hi_d;
    logic [2:0]            state_q, state_d;
    logic [2:0]            sel_q, sel_d;
    logic [DATA_WIDTH-1:0] opd_q, opd_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [IDX_W-1:0]      iout_q, iout_d;
    logic                  rv_q, rv_d;
    logic                  err_q, err_d;

    logic                  do_clr, do_del, do_ins;
    logic [IDX_W-1:0]      del_pos;
    logic [CNT_W-1:0]      ins_pos;
    logic [CNT_W-1:0]      loc_pos;
    logic                  loc_dup;
    logic [CNT_W:0]        mid_sum;
    logic [CNT_W-1:0]      mid;
    logic [DATA_WIDTH-1:0] mid_ent;
    logic [DATA_WIDTH-1:0] lo_ent;
    logic                  lo_match;
    logic                  in_range;
    logic [IDX_W-1:0]      mm_idx;

    function automatic logic precedes(input logic [DATA_WIDTH-1:0] a,
                                      input logic [DATA_WIDTH-1:0] b);
        if (ORDER == 0) return a < b;
        return a > b;
    endfunction

    // Insert position: entries that precede or equal the operand, so equal values stay FIFO-ordered.
    always_comb begin
        loc_pos = '0;
        loc_dup = 1'b0;
        for (int i = 0; i < LENGTH; i++) begin
            if (CNT_W'(i) < len_q) begin
                if (!precedes(opd_q, mem_q[i])) loc_pos = loc_pos + ONE;
                if (mem_q[i] == opd_q)          loc_dup = 1'b1;
            end
        end
    end

    assign mid_sum  = {1'b0, lo_q} + {1'b0, hi_q};
    assign mid      = mid_sum[CNT_W:1];
    assign mid_ent  = mem_q[IDX_W'(mid)];
    assign lo_ent   = (lo_q < len_q) ? mem_q[IDX_W'(lo_q)] : '0;
    assign lo_match = (lo_q < len_q) && (lo_ent == opd_q);
    assign in_range = CNT_W'(index_in) < len_q;
    assign mm_idx   = ((op_sel == OP_MIN) == (ORDER == 0)) ? '0 : IDX_W'(len_q - ONE);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        opd_d   = opd_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        len_d   = len_q;
        dout_d  = dout_q;
        iout_d  = iout_q;
        rv_d    = 1'b0;
        err_d   = 1'b0;
        do_clr  = 1'b0;
        do_del  = 1'b0;
        do_ins  = 1'b0;
        del_pos = '0;
        ins_pos = '0;

        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    sel_d = op_sel;
                    opd_d = data_in;
                    lo_d  = '0;
                    hi_d  = len_q;
                    case (op_sel)
                        OP_INSERT: state_d = S_LOCATE;
                        OP_FIND, OP_DEL_VAL: state_d = (len_q == '0) ? S_CHECK : S_SEARCH;
                        default: begin
                            state_d = S_RESP;
                            rv_d    = 1'b1;
                            case (op_sel)
                                OP_READ: begin
                                    if (in_range) begin
                                        dout_d = mem_q[index_in];
                                        iout_d = index_in;
                                    end else begin
                                        err_d = 1'b1;
                                    end
                                end
                                OP_DEL_IDX: begin
                                    if (in_range) begin
                                        dout_d  = mem_q[index_in];
                                        iout_d  = index_in;
                                        do_del  = 1'b1;
                                        del_pos = index_in;
                                        len_d   = len_q - ONE;
                                    end else begin
                                        err_d = 1'b1;
                                    end
                                end
                                OP_MIN, OP_MAX: begin
                                    if (len_q == '0) begin
                                        err_d = 1'b1;
                                    end else begin
                                        dout_d = mem_q[mm_idx];
                                        iout_d = mm_idx;
                                    end
                                end
                                default: begin
                                    do_clr = 1'b1;
                                    len_d  = '0;
                                end
                            endcase
                        end
                    endcase
                end
            end
            S_LOCATE: begin
                state_d = S_RESP;
                rv_d    = 1'b1;
                if (len_q == LEN_MAX || (ALLOW_DUP == 0 && loc_dup)) begin
                    err_d = 1'b1;
                end else begin
                    do_ins  = 1'b1;
                    ins_pos = loc_pos;
                    len_d   = len_q + ONE;
                    iout_d  = IDX_W'(loc_pos);
                    dout_d  = opd_q;
                end
            end
            S_SEARCH: begin
                // Lower-bound search; moving to CHECK on the step that closes the window saves a cycle.
                if (precedes(mid_ent, opd_q)) lo_d = mid + ONE;
                else                          hi_d = mid;
                if (lo_d == hi_d) state_d = S_CHECK;
            end
            S_CHECK: begin
                state_d = S_RESP;
                rv_d    = 1'b1;
                if (sel_q == OP_FIND) begin
                    iout_d = IDX_W'(lo_q);
                    if (lo_match) dout_d = lo_ent;
                    else          err_d  = 1'b1;
                end else if (lo_match) begin
                    dout_d  = lo_ent;
                    iout_d  = IDX_W'(lo_q);
                    do_del  = 1'b1;
                    del_pos = IDX_W'(lo_q);
                    len_d   = len_q - ONE;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < LENGTH; i++) mem_d[i] = mem_q[i];
        if (do_clr) begin
            for (int i = 0; i < LENGTH; i++) mem_d[i] = '0;
        end
        if (do_del) begin
            for (int i = 0; i < LENGTH - 1; i++) begin
                if (IDX_W'(i) >= del_pos) mem_d[i] = mem_q[i + 1];
            end
            mem_d[LENGTH-1] = '0;
        end
        if (do_ins) begin
            for (int i = 1; i < LENGTH; i++) begin
                if (CNT_W'(i) > ins_pos) mem_d[i] = mem_q[i - 1];
            end
            mem_d[IDX_W'(ins_pos)] = opd_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LENGTH; i++) mem_q[i] <= '0;
            state_q <= S_IDLE;
            sel_q   <= '0;
            opd_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            len_q   <= '0;
            dout_q  <= '0;
            iout_q  <= '0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < LENGTH; i++) mem_q[i] <= mem_d[i];
            state_q <= state_d;
            sel_q   <= sel_d;
            opd_q   <= opd_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            len_q   <= len_d;
            dout_q  <= dout_d;
            iout_q  <= iout_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
        end
    end

    assign op_ready  = (state_q == S_IDLE);
    assign data_out  = dout_q;
    assign index_out = iout_q;
    assign res_valid = rv_q;
    assign op_error  = err_q;
    assign len       = len_q;
    assign full      = (len_q == LEN_MAX);
    assign empty     = (len_q == '0);

endmodule

// File: tb/tb_sorted_list.sv
// Bench for sorted_list: three instances (ascending, ascending without duplicates, descending),
// directed scenarios plus random operations against a queue-based reference model.
module tb_sorted_list;

    localparam int CW = 4;
    localparam logic [2:0] RD = 3'd0, INS = 3'd1, FND = 3'd2, DLI = 3'd3;
    localparam logic [2:0] DLV = 3'd4, MN = 3'd5, MX = 3'd6, CLR = 3'd7;

    logic        clk;
    logic        rst_n;
    logic        op_valid  [3];
    logic        op_ready  [3];
    logic [2:0]  op_sel    [3];
    logic [31:0] data_in   [3];
    logic [2:0]  index_in  [3];
    logic [31:0] data_out  [3];
    logic [2:0]  index_out [3];
    logic        res_valid [3];
    logic        op_error  [3];
    logic [3:0]  len       [3];
    logic        full      [3];
    logic        empty     [3];

    int n_checks;
    int n_fail;

    logic [31:0] mq[$];
    int          m_ord;
    int          m_ad;
    logic [31:0] m_d;
    logic [2:0]  m_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sorted_list #(
            .DATA_WIDTH(32),
            .LENGTH    (8),
            .ORDER     ((g == 2) ? 1 : 0),
            .ALLOW_DUP ((g == 1) ? 0 : 1)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .op_valid (op_valid[g]),
            .op_ready (op_ready[g]),
            .op_sel   (op_sel[g]),
            .data_in  (data_in[g]),
            .index_in (index_in[g]),
            .data_out (data_out[g]),
            .index_out(index_out[g]),
            .res_valid(res_valid[g]),
            .op_error (op_error[g]),
            .len      (len[g]),
            .full     (full[g]),
            .empty    (empty[g])
        );
    end

    function automatic bit prec(input logic [31:0] a, input logic [31:0] b, input int ord);
        return (ord == 0) ? (a < b) : (a > b);
    endfunction

    // Reference model: a sorted queue; searches are plain linear scans.
    task automatic model_op(input logic [2:0] s, input logic [31:0] d, input logic [2:0] ix,
                            output logic err, output int llo, output int lhi);
        int n = mq.size();
        int p = 0;
        int lo;
        bit dup = 0;
        err = 1'b0; llo = 1; lhi = 1;
        case (s)
            RD: if (int'(ix) < n) begin m_d = mq[ix]; m_i = ix; end else err = 1'b1;
            INS: begin
                llo = 2; lhi = 2;
                foreach (mq[k]) begin
                    if (!prec(d, mq[k], m_ord)) p++;
                    if (mq[k] == d) dup = 1;
                end
                if (n == 8 || (m_ad == 0 && dup)) err = 1'b1;
                else begin mq.insert(p, d); m_d = d; m_i = 3'(p); end
            end
            FND, DLV: begin
                llo = (n == 0) ? 2 : 3;
                lhi = (n == 0) ? 2 : CW + 2;
                lo = n;
                for (int k = 0; k < n; k++) if (!prec(mq[k], d, m_ord)) begin lo = k; break; end
                if (lo < n && mq[lo] == d) begin
                    m_d = mq[lo]; m_i = 3'(lo);
                    if (s == DLV) mq.delete(lo);
                end else begin
                    err = 1'b1;
                    if (s == FND) m_i = 3'(lo);
                end
            end
            DLI: if (int'(ix) < n) begin m_d = mq[ix]; m_i = ix; mq.delete(int'(ix)); end else err = 1'b1;
            MN, MX: begin
                if (n == 0) err = 1'b1;
                else begin
                    p = ((s == MN) == (m_ord == 0)) ? 0 : n - 1;
                    m_d = mq[p]; m_i = 3'(p);
                end
            end
            default: mq.delete();
        endcase
    endtask

    task automatic wait_ready(input int u);
        int w = 0;
        @(negedge clk);
        while (op_ready[u] !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        if (w >= 50) begin n_checks++; n_fail++; $display("FAIL ready_timeout unit %0d", u); end
    endtask

    task automatic do_op(input int u, input logic [2:0] s, input logic [31:0] d, input logic [2:0] ix,
                         output logic [31:0] dout, output logic [2:0] iout, output logic err, output int lat);
        wait_ready(u);
        op_valid[u] = 1'b1; op_sel[u] = s; data_in[u] = d; index_in[u] = ix;
        @(posedge clk); #1;
        op_valid[u] = 1'b0; op_sel[u] = 3'($urandom); data_in[u] = $urandom; index_in[u] = 3'($urandom);
        lat = 1;
        while (res_valid[u] !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
        if (lat >= 50) begin n_checks++; n_fail++; $display("FAIL res_valid_timeout unit %0d op %0d", u, s); end
        dout = data_out[u]; iout = index_out[u]; err = op_error[u];
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [2:0] i; logic e; int lat;
        for (int u = 0; u < 3; u++) begin
            n_checks++; if (op_ready[u] !== 1'b1) begin n_fail++; $display("FAIL rst_ready u%0d got %b want 1", u, op_ready[u]); end
            n_checks++; if (len[u] !== 4'd0) begin n_fail++; $display("FAIL rst_len u%0d got %0d want 0", u, len[u]); end
            n_checks++; if (empty[u] !== 1'b1 || full[u] !== 1'b0) begin n_fail++; $display("FAIL rst_flags u%0d got e%b f%b want e1 f0", u, empty[u], full[u]); end
            n_checks++; if (res_valid[u] !== 1'b0 || op_error[u] !== 1'b0) begin n_fail++; $display("FAIL rst_res u%0d got v%b e%b want 0 0", u, res_valid[u], op_error[u]); end
            n_checks++; if (data_out[u] !== 32'd0 || index_out[u] !== 3'd0) begin n_fail++; $display("FAIL rst_out u%0d got %0h/%0d want 0/0", u, data_out[u], index_out[u]); end
        end
        do_op(0, RD, 0, 0, d, i, e, lat);
        n_checks++; if (e !== 1'b1 || lat !== 1) begin n_fail++; $display("FAIL read_empty got err %b lat %0d want 1 1", e, lat); end
    endtask

    task automatic test_insert();
        logic [31:0] vals[4]; logic [2:0] ei[4]; logic [31:0] ord[4];
        logic [31:0] d; logic [2:0] i; logic e; int lat;
        vals = '{5, 2, 9, 2}; ei = '{0, 0, 2, 1}; ord = '{2, 2, 5, 9};
        for (int k = 0; k < 4; k++) begin
            do_op(0, INS, vals[k], 0, d, i, e, lat);
            n_checks++; if (i !== ei[k] || e !== 1'b0 || d !== vals[k]) begin n_fail++; $display("FAIL insert%0d got idx %0d err %b d %0d want %0d 0 %0d", k, i, e, d, ei[k], vals[k]); end
            n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL insert_lat%0d got %0d want 2", k, lat); end
        end
        n_checks++; if (len[0] !== 4'd4) begin n_fail++; $display("FAIL insert_len got %0d want 4", len[0]); end
        for (int k = 0; k < 4; k++) begin
            do_op(0, RD, 0, 3'(k), d, i, e, lat);
            n_checks++; if (d !== ord[k] || e !== 1'b0 || lat !== 1) begin n_fail++; $display("FAIL order%0d got %0d err %b lat %0d want %0d", k, d, e, lat, ord[k]); end
        end
    endtask

    task automatic test_find();
        logic [31:0] d; logic [2:0] i; logic e; int lat;
        do_op(0, FND, 5, 0, d, i, e, lat);
        n_checks++; if (i !== 3'd2 || e !== 1'b0 || d !== 32'd5) begin n_fail++; $display("FAIL find5 got idx %0d err %b d %0d want 2 0 5", i, e, d); end
        n_checks++; if (lat < 3 || lat > CW + 2) begin n_fail++; $display("FAIL find5_lat got %0d want 3..%0d", lat, CW + 2); end
        do_op(0, FND, 7, 0, d, i, e, lat);
        n_checks++; if (i !== 3'd3 || e !== 1'b1 || d !== 32'd5) begin n_fail++; $display("FAIL find7 got idx %0d err %b d %0d want 3 1 5", i, e, d); end
        n_checks++; if (lat < 3 || lat > CW + 2) begin n_fail++; $display("FAIL find7_lat got %0d want 3..%0d", lat, CW + 2); end
        do_op(0, FND, 2, 0, d, i, e, lat);
        n_checks++; if (i !== 3'd0 || e !== 1'b0) begin n_fail++; $display("FAIL find2_first got idx %0d err %b want 0 0", i, e); end
    endtask

    task automatic test_delete();
        logic [31:0] d; logic [2:0] i; logic e; int lat;
        do_op(0, DLV, 2, 0, d, i, e, lat);
        n_checks++; if (d !== 32'd2 || i !== 3'd0 || e !== 1'b0 || len[0] !== 4'd3) begin n_fail++; $display("FAIL delval2 got d %0d idx %0d err %b len %0d want 2 0 0 3", d, i, e, len[0]); end
        do_op(0, DLI, 0, 2, d, i, e, lat);
        n_checks++; if (d !== 32'd9 || i !== 3'd2 || e !== 1'b0 || len[0] !== 4'd2 || lat !== 1) begin n_fail++; $display("FAIL delidx2 got d %0d idx %0d err %b len %0d lat %0d want 9 2 0 2 1", d, i, e, len[0], lat); end
        n_checks++; if (g_dut[0].u_dut.mem_q[2] !== 32'd0) begin n_fail++; $display("FAIL slot2_zero got %0h want 0", g_dut[0].u_dut.mem_q[2]); end
        do_op(0, DLI, 0, 5, d, i, e, lat);
        n_checks++; if (e !== 1'b1 || d !== 32'd9 || i !== 3'd2) begin n_fail++; $display("FAIL delidx_oob got err %b d %0d idx %0d want 1 9 2", e, d, i); end
        do_op(0, DLV, 100, 0, d, i, e, lat);
        n_checks++; if (e !== 1'b1 || len[0] !== 4'd2 || i !== 3'd2) begin n_fail++; $display("FAIL delval_miss got err %b len %0d idx %0d want 1 2 2", e, len[0], i); end
    endtask

    task automatic test_full();
        logic [31:0] add[6]; logic [31:0] d; logic [2:0] i; logic e; int lat;
        add = '{1, 3, 4, 8, 6, 7};
        for (int k = 0; k < 6; k++) do_op(0, INS, add[k], 0, d, i, e, lat);
        n_checks++; if (full[0] !== 1'b1 || len[0] !== 4'd8) begin n_fail++; $display("FAIL full got %b len %0d want 1 8", full[0], len[0]); end
        do_op(0, INS, 0, 0, d, i, e, lat);
        n_checks++; if (e !== 1'b1 || len[0] !== 4'd8) begin n_fail++; $display("FAIL ins_full got err %b len %0d want 1 8", e, len[0]); end
        for (int k = 0; k < 8; k++) begin
            do_op(0, RD, 0, 3'(k), d, i, e, lat);
            n_checks++; if (d !== 32'(k + 1)) begin n_fail++; $display("FAIL full_slot%0d got %0d want %0d", k, d, k + 1); end
        end
        do_op(0, MN, 0, 0, d, i, e, lat);
        n_checks++; if (d !== 32'd1 || i !== 3'd0 || e !== 1'b0) begin n_fail++; $display("FAIL min_asc got %0d@%0d want 1@0", d, i); end
        do_op(0, MX, 0, 0, d, i, e, lat);
        n_checks++; if (d !== 32'd8 || i !== 3'd7 || e !== 1'b0) begin n_fail++; $display("FAIL max_asc got %0d@%0d want 8@7", d, i); end
    endtask

    task automatic test_nodup();
        logic [31:0] d; logic [2:0] i; logic e; int lat;
        do_op(1, INS, 4, 0, d, i, e, lat);
        n_checks++; if (e !== 1'b0 || i !== 3'd0) begin n_fail++; $display("FAIL nodup_first got err %b idx %0d want 0 0", e, i); end
        do_op(1, INS, 4, 0, d, i, e, lat);
        n_checks++; if (e !== 1'b1 || len[1] !== 4'd1) begin n_fail++; $display("FAIL nodup_reject got err %b len %0d want 1 1", e, len[1]); end
        do_op(1, INS, 3, 0, d, i, e, lat);
        n_checks++; if (e !== 1'b0 || i !== 3'd0 || len[1] !== 4'd2) begin n_fail++; $display("FAIL nodup_other got err %b idx %0d len %0d want 0 0 2", e, i, len[1]); end
    endtask

    task automatic test_order1();
        logic [31:0] vals[3]; logic [2:0] ei[3]; logic [31:0] ord[3];
        logic [31:0] d; logic [2:0] i; logic e; int lat;
        vals = '{3, 7, 1}; ei = '{0, 0, 2}; ord = '{7, 3, 1};
        for (int k = 0; k < 3; k++) begin
            do_op(2, INS, vals[k], 0, d, i, e, lat);
            n_checks++; if (i !== ei[k] || e !== 1'b0) begin n_fail++; $display("FAIL desc_ins%0d got idx %0d err %b want %0d 0", k, i, e, ei[k]); end
        end
        for (int k = 0; k < 3; k++) begin
            do_op(2, RD, 0, 3'(k), d, i, e, lat);
            n_checks++; if (d !== ord[k]) begin n_fail++; $display("FAIL desc_order%0d got %0d want %0d", k, d, ord[k]); end
        end
        do_op(2, MN, 0, 0, d, i, e, lat);
        n_checks++; if (d !== 32'd1 || i !== 3'd2 || e !== 1'b0) begin n_fail++; $display("FAIL desc_min got %0d@%0d want 1@2", d, i); end
        do_op(2, MX, 0, 0, d, i, e, lat);
        n_checks++; if (d !== 32'd7 || i !== 3'd0 || e !== 1'b0) begin n_fail++; $display("FAIL desc_max got %0d@%0d want 7@0", d, i); end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        wait_ready(2);
        op_valid[2] = 1'b1; op_sel[2] = RD; data_in[2] = 0; index_in[2] = 3'd0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            exp_v = (k % 2 == 0);
            n_checks++; if (res_valid[2] !== exp_v || op_ready[2] !== !exp_v) begin n_fail++; $display("FAIL b2b_edge%0d got v%b r%b want v%b r%b", k, res_valid[2], op_ready[2], exp_v, !exp_v); end
            if (exp_v) begin
                n_checks++; if (data_out[2] !== 32'd7) begin n_fail++; $display("FAIL b2b_data%0d got %0d want 7", k, data_out[2]); end
            end
        end
        op_valid[2] = 1'b0;
    endtask

    task automatic test_reset_abort();
        int bad = 0;
        wait_ready(0);
        op_valid[0] = 1'b1; op_sel[0] = FND; data_in[0] = 5; index_in[0] = 0;
        @(posedge clk); #1;
        op_valid[0] = 1'b0;
        n_checks++; if (res_valid[0] !== 1'b0 || op_ready[0] !== 1'b0) begin n_fail++; $display("FAIL abort_busy got v%b r%b want 0 0", res_valid[0], op_ready[0]); end
        @(negedge clk); rst_n = 1'b0; #1;
        n_checks++; if (len[0] !== 4'd0 || empty[0] !== 1'b1 || op_ready[0] !== 1'b1) begin n_fail++; $display("FAIL abort_clear got len %0d e%b r%b want 0 1 1", len[0], empty[0], op_ready[0]); end
        n_checks++; if (data_out[0] !== 32'd0 || g_dut[0].u_dut.mem_q[0] !== 32'd0) begin n_fail++; $display("FAIL abort_state got d %0h slot0 %0h want 0 0", data_out[0], g_dut[0].u_dut.mem_q[0]); end
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin @(posedge clk); #1; if (res_valid[0] !== 1'b0) bad++; end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL abort_no_result got %0d strobes want 0", bad); end
    endtask

    task automatic test_random(input int u, input int nops);
        logic [2:0] s, ix, i; logic [31:0] dv, d; logic e, ee; int lat, llo, lhi;
        m_ord = (u == 2) ? 1 : 0;
        m_ad  = (u == 1) ? 0 : 1;
        do_op(u, CLR, 0, 0, d, i, e, lat);
        mq.delete();
        n_checks++; if (e !== 1'b0 || len[u] !== 4'd0 || lat !== 1) begin n_fail++; $display("FAIL clear u%0d got err %b len %0d lat %0d want 0 0 1", u, e, len[u], lat); end
        for (int k = 0; k < nops; k++) begin
            s  = 3'($urandom_range(0, 7));
            if (s == CLR && $urandom_range(0, 9) != 0) s = INS;
            if (k == 0) s = INS;
            dv = 32'($urandom_range(0, 12));
            ix = 3'($urandom_range(0, 7));
            model_op(s, dv, ix, ee, llo, lhi);
            do_op(u, s, dv, ix, d, i, e, lat);
            n_checks++; if (e !== ee) begin n_fail++; $display("FAIL rnd_err u%0d op%0d v%0d got %b want %b", u, s, dv, e, ee); end
            if (s != CLR) begin
                n_checks++; if (d !== m_d || i !== m_i) begin n_fail++; $display("FAIL rnd_out u%0d op%0d v%0d got %0d@%0d want %0d@%0d", u, s, dv, d, i, m_d, m_i); end
            end
            n_checks++; if (int'(len[u]) != mq.size() || full[u] !== (mq.size() == 8) || empty[u] !== (mq.size() == 0)) begin n_fail++; $display("FAIL rnd_len u%0d got %0d want %0d", u, len[u], mq.size()); end
            n_checks++; if (lat < llo || lat > lhi) begin n_fail++; $display("FAIL rnd_lat u%0d op%0d got %0d want %0d..%0d", u, s, lat, llo, lhi); end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        for (int u = 0; u < 3; u++) begin
            op_valid[u] = 1'b0; op_sel[u] = 3'd0; data_in[u] = 32'd0; index_in[u] = 3'd0;
        end
        #22 rst_n = 1'b1;
        test_reset();
        test_insert();
        test_find();
        test_delete();
        test_full();
        test_nodup();
        test_order1();
        test_back_to_back();
        test_reset_abort();
        test_random(0, 200);
        test_random(1, 150);
        test_random(2, 150);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sorted_list.md
# sorted_list

Parametrised successor to the list block. Keeps up to LENGTH unsigned entries permanently sorted (ascending or descending by parameter) and services one operation at a time over a valid/ready request port with a single-cycle result pulse. Insert positions itself automatically, and value lookup uses a multi-cycle binary search instead of a linear scan. It sits beside the list block as the storage engine for priority and lookup tables.

## Interface
- DATA_WIDTH, 32, entry width; entries compare as unsigned.
- LENGTH, 8, capacity; must be ≥2. IDX_W = $clog2(LENGTH), CNT_W = $clog2(LENGTH+1).
- ORDER, 0, 0 = ascending (index 0 smallest), 1 = descending (index 0 largest).
- ALLOW_DUP, 1, 0 = INSERT of a value already present is rejected with an error.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  request valid.
- op_ready  out  1  block can accept a request; high only in IDLE.
- op_sel  in  3  000 READ, 001 INSERT, 010 FIND, 011 DELETE_IDX, 100 DELETE_VAL, 101 MIN, 110 MAX, 111 CLEAR.
- data_in  in  DATA_WIDTH  operand value.
- index_in  in  IDX_W  operand index.
- data_out  out  DATA_WIDTH  result value.
- index_out  out  IDX_W  result index.
- res_valid  out  1  one-cycle result strobe.
- op_error  out  1  qualifies res_valid; meaningful only while res_valid is high.
- len  out  CNT_W  current entry count.
- full / empty  out  1 each  combinational: len==LENGTH / len==0.

## Operation
- Request handshake: the request is accepted on an edge where op_valid && op_ready. At that edge op_sel, data_in and index_in are registered. op_valid while op_ready is low is ignored and not buffered.
- Precedence rule:
  - ORDER=0: a precedes b iff a<b.
  - ORDER=1: a precedes b iff a>b.
- Storage invariants: entries [0,len) are sorted under the precedence rule. Slots ≥len always hold 0.
- FSM states: IDLE, LOCATE, SEARCH, CHECK, RESP.
  - RESP drives res_valid=1 for exactly one cycle, then returns to IDLE.
- READ: if index_in<len, data_out=entry[index_in] and index_out=index_in. Otherwise op_error. Path: IDLE→RESP.
- MIN / MAX:
  - MIN returns entry[0] when ORDER=0 and entry[len-1] when ORDER=1; MAX is the converse.
  - index_out is the entry's index.
  - Empty list → op_error. Path: IDLE→RESP.
- CLEAR: len=0 and all slots zeroed. Never errors. Path: IDLE→RESP.
- DELETE_IDX:
  - If index_in<len: data_out = the removed value, index_out=index_in, entries above it shift down by one, the vacated top slot is zeroed, len decrements.
  - Otherwise op_error. Path: IDLE→RESP.
- INSERT (IDLE→LOCATE→RESP):
  - LOCATE computes the position p = the count of valid entries that precede or equal data_in, so the new entry lands after any equal entries. It also computes a dup flag.
  - Rejected with op_error, storage untouched, if full, or if ALLOW_DUP=0 and dup.
  - Otherwise entries [p,len) shift up, entry[p]=data_in, len increments, index_out=p, data_out=data_in.
- FIND / DELETE_VAL (IDLE→SEARCH→CHECK→RESP):
  - At acceptance: lo=0, hi=len.
  - Each SEARCH cycle with lo≠hi: mid=(lo+hi)>>1. If entry[mid] precedes data_in then lo=mid+1, else hi=mid.
  - lo==hi → CHECK. Match means lo<len && entry[lo]==data_in, i.e. the first equal entry.
  - FIND: index_out=lo even when there is no match (lo is then the insertion point). data_out=entry[lo] on a match. No match → op_error.
  - DELETE_VAL on a match: delete entry[lo] exactly as DELETE_IDX does, data_out = the removed value. No match → op_error, storage untouched.
- On error, data_out holds its previous value, and so does index_out except for FIND.
- Outputs are all registered except full and empty.

## Timing
- Reset values: state IDLE, op_ready=1, res_valid=0, op_error=0, data_out=0, index_out=0, len=0, all slots 0.
- Reset asserted mid-operation aborts immediately. Storage clears with no res_valid.
- Latency is counted in edges from the acceptance edge to the edge that raises res_valid:
  - READ, MIN, MAX, CLEAR, DELETE_IDX: 1.
  - INSERT: 2.
  - FIND, DELETE_VAL: k+2, where k = number of halving steps (≤CNT_W). An empty list gives 2.
- Storage and len updates are visible in the same cycle as res_valid.
- op_ready is low from the acceptance edge through the RESP cycle. The next request can be accepted one edge after res_valid falls, so back-to-back throughput is one op per latency+1 cycles.
- Changes to op_sel, data_in or index_in after acceptance have no effect.

## Test plan
- Reset, LENGTH=8, ORDER=0 → op_ready=1, len=0, empty=1. READ idx 0 → op_error=1 after 1 edge.
- INSERT 5,2,9,2 → index_out 0,0,2,1. Final order [2,2,5,9], len=4. Each res_valid arrives 2 edges after acceptance.
- FIND 5 → index_out=2, op_error=0. FIND 7 → op_error=1, index_out=3. Both within CNT_W+2 edges.
- DELETE_VAL 2 → data_out=2, remaining [2,5,9]. DELETE_IDX 2 → data_out=9, len=2, slot 2 reads as 0 internally.
- Fill to 8 entries → full=1. 9th INSERT → op_error=1, storage unchanged. ALLOW_DUP=0: INSERT of an existing value → op_error=1.
- ORDER=1: insert 3,7,1 → [7,3,1]. MIN=1 at index 2, MAX=7 at index 0. Assert rst_n during a SEARCH → len=0, no res_valid.
